// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard-sequencer bundle: hazard information from the ID/EX pipeline and the
// stall/bubble/flush controls returned to it.
interface pipeline_hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic             idex_muldiv;
    logic             branch_taken_ex;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             ifid_flush;
    logic             idex_flush;
    logic             forward_enable;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline datapath side: supplies hazard info, consumes controls.
    modport master (
        output id_rs, id_rt, idex_memread, idex_rt, idex_muldiv, branch_taken_ex,
        input  pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble,
               ifid_flush, idex_flush, forward_enable, stall_cycles
    );

    // Sequencer side.
    modport slave (
        input  id_rs, id_rt, idex_memread, idex_rt, idex_muldiv, branch_taken_ex,
        output pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble,
               ifid_flush, idex_flush, forward_enable, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// ID/EX hazard sequencer: load-use stalls, multi-cycle mul/div occupancy of EX,
// taken-branch flushes, forwarding gating and a saturating stall counter.
module pipeline_hazard_sequencer #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    pipeline_hazard_sequencer_if.slave     hz
);
    typedef enum logic [1:0] {RUN, MD_WAIT, MD_REL} state_t;

    // The RUN cycle that starts a mul/div and the MD_REL cycle bracket the
    // MD_WAIT cycles, so MD_WAIT lasts MD_LAT-3 extra counts beyond the first.
    localparam bit         MD_STALLS = (MD_LAT > 1);
    localparam state_t     MD_ENTRY  = (MD_LAT > 2) ? MD_WAIT : MD_REL;
    localparam int         MD_INIT_I = (MD_LAT > 2) ? (MD_LAT - 3) : 0;
    localparam logic [3:0] MD_INIT   = MD_INIT_I[3:0];

    state_t           state_reg, state_next;
    logic [3:0]       md_cnt_reg, md_cnt_next;
    logic [CNT_W-1:0] stall_cycles_reg;
    logic             forward_enable_reg;

    logic pc_write, ifid_write, idex_write;
    logic idex_bubble, exmem_bubble, ifid_flush, idex_flush;
    logic load_use;

    assign load_use = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                      ((hz.idex_rt == hz.id_rs) || (hz.idex_rt == hz.id_rt));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        state_next   = state_reg;
        md_cnt_next  = md_cnt_reg;

        // While reset is held the controls must read as defaults whatever the inputs.
        if (rst_n) begin
            case (state_reg)
                MD_WAIT: begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    if (md_cnt_reg == 4'd0) begin
                        state_next = MD_REL;
                    end else begin
                        md_cnt_next = md_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    if (state_reg == MD_REL) begin
                        state_next = RUN;
                    end
                    if (hz.branch_taken_ex) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if ((state_reg == RUN) && hz.idex_muldiv && MD_STALLS) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                        state_next   = MD_ENTRY;
                        md_cnt_next  = MD_INIT;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= RUN;
            md_cnt_reg         <= 4'd0;
            stall_cycles_reg   <= '0;
            forward_enable_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            md_cnt_reg         <= md_cnt_next;
            forward_enable_reg <= (state_next != MD_WAIT);
            if (!pc_write && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
        end
    end

    assign hz.pc_write       = pc_write;
    assign hz.ifid_write     = ifid_write;
    assign hz.idex_write     = idex_write;
    assign hz.idex_bubble    = idex_bubble;
    assign hz.exmem_bubble   = exmem_bubble;
    assign hz.ifid_flush     = ifid_flush;
    assign hz.idex_flush     = idex_flush;
    assign hz.forward_enable = forward_enable_reg;
    assign hz.stall_cycles   = stall_cycles_reg;
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer (MD_LAT = 4, CNT_W = 4) with
// hand-computed control vectors and stall counts.
module tb_pipeline_hazard_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Control vector order: pc_write, ifid_write, idex_write, idex_bubble,
    // exmem_bubble, ifid_flush, idex_flush.
    localparam logic [6:0] DEF = 7'b1110000;
    localparam logic [6:0] LU  = 7'b0011000;
    localparam logic [6:0] MD  = 7'b0000100;
    localparam logic [6:0] FL  = 7'b1110011;

    pipeline_hazard_sequencer_if #(.CNT_W(4)) bus ();

    pipeline_hazard_sequencer #(.MD_LAT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                         input logic [4:0] xrt, input logic md, input logic br);
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.idex_memread    = mr;
        bus.idex_rt         = xrt;
        bus.idex_muldiv     = md;
        bus.branch_taken_ex = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ctrl();
        return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.idex_bubble,
                bus.exmem_bubble, bus.ifid_flush, bus.idex_flush};
    endfunction

    task automatic cyc(input string tag, input logic [6:0] exp_ctrl,
                       input logic exp_fe, input logic [3:0] exp_cnt);
        @(negedge clk);
        check({tag, "_ctrl"}, 16'(ctrl()), 16'(exp_ctrl));
        check({tag, "_fe"},   16'(bus.forward_enable), 16'(exp_fe));
        check({tag, "_cnt"},  16'(bus.stall_cycles), 16'(exp_cnt));
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            drive(5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom));
            cyc("rst", DEF, 1'b0, 4'd0);
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc("rel0", DEF, 1'b0, 4'd0);
        cyc("rel1", DEF, 1'b1, 4'd0);

        // Load-use on rs, then on rt, then the non-hazard cases
        drive(5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
        cyc("lu_rs", LU, 1'b1, 4'd0);
        drive(5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        cyc("lu_rt", LU, 1'b1, 4'd1);
        drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        cyc("lu_r0", DEF, 1'b1, 4'd2);
        drive(5'd8, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0);
        cyc("no_ld", DEF, 1'b1, 4'd2);

        // Branch flush beats load-use
        drive(5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1);
        cyc("flush", FL, 1'b1, 4'd2);

        // Mul/div: 3 stall cycles, branch ignored in MD_WAIT, then MD_REL
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("md_a", MD, 1'b1, 4'd2);
        drive(5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1);
        cyc("md_b", MD, 1'b0, 4'd3);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("md_c", MD, 1'b0, 4'd4);
        cyc("md_rel", DEF, 1'b1, 4'd5);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("md_run", DEF, 1'b1, 4'd5);

        // Mul/div and load-use together: mul/div wins, load-use returns in MD_REL
        drive(5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        cyc("mdl_a", MD, 1'b1, 4'd5);
        cyc("mdl_b", MD, 1'b0, 4'd6);
        cyc("mdl_c", MD, 1'b0, 4'd7);
        cyc("mdl_rel", LU, 1'b1, 4'd8);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("mdl_run", DEF, 1'b1, 4'd9);

        // Reset asserted in the second MD_WAIT cycle
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("mr_a", MD, 1'b1, 4'd9);
        cyc("mr_b", MD, 1'b0, 4'd10);
        drive(5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1);
        #1;
        check("mr_c_ctrl", 16'(ctrl()), 16'(MD));
        check("mr_c_cnt", 16'(bus.stall_cycles), 16'd11);
        rst_n = 1'b0;
        #1;
        check("mr_rst_ctrl", 16'(ctrl()), 16'(DEF));
        check("mr_rst_cnt", 16'(bus.stall_cycles), 16'd0);
        check("mr_rst_fe", 16'(bus.forward_enable), 16'd0);
        cyc("mr_hold", DEF, 1'b0, 4'd0);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc("mr_rel", DEF, 1'b0, 4'd0);
        // A fresh mul/div stalls immediately only if the state is RUN
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("mr_run", MD, 1'b1, 4'd0);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("mr_wait", MD, 1'b0, 4'd1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Saturation: 20 load-use cycles with a 4-bit counter
        drive(5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("sat%0d", i), 16'(bus.stall_cycles), (i < 15) ? 16'(i) : 16'd15);
            tick();
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("sat_end", DEF, 1'b1, 4'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
